// File: rtl/shift_sequencer.sv
// Multi-pass shift sequencer: repeatedly drives an external single-pass shifter
// and registers the final word/carry, with a one-cycle done pulse.

package shift_sequencer_pkg;

  typedef logic [15:0] MICRO1_MACHINE_WORD;

  typedef enum logic [2:0] {
    PASS_THROUGH         = 3'd0,
    LEFT_LOGICALLY       = 3'd1,
    RIGHT_LOGICALLY      = 3'd2,
    LEFT_ARITHMETICALLY  = 3'd3,
    RIGHT_ARITHMETICALLY = 3'd4,
    EXTENSION            = 3'd5,
    SWAP                 = 3'd6
  } SHIFTER_OPERATION;

endpackage

module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int COUNT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  SHIFTER_OPERATION       operation,
  input  MICRO1_MACHINE_WORD     in,
  input  logic [COUNT_WIDTH-1:0] count,
  input  logic                   cin,
  output SHIFTER_OPERATION       shifter_operation,
  output MICRO1_MACHINE_WORD     shifter_in,
  output logic                   shifter_cin,
  input  MICRO1_MACHINE_WORD     shifter_out,
  input  logic                   shifter_cout,
  output MICRO1_MACHINE_WORD     out,
  output logic                   cout,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  SHIFTER_OPERATION       op_q, op_d;
  MICRO1_MACHINE_WORD     work_q, work_d;
  MICRO1_MACHINE_WORD     out_q, out_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   cin_q, cin_d;
  logic                   carry_q, carry_d;
  logic                   cout_q, cout_d;
  logic [COUNT_WIDTH-1:0] effCount;

  // Only the true shift kinds honour count; every other operation is one pass.
  always_comb begin
    case (operation)
      LEFT_LOGICALLY, RIGHT_LOGICALLY,
      LEFT_ARITHMETICALLY, RIGHT_ARITHMETICALLY: effCount = count;
      default:                                   effCount = COUNT_WIDTH'(1);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= PASS_THROUGH;
      work_q  <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      cin_q   <= cin_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    op_d              = op_q;
    work_d            = work_q;
    out_d             = out_q;
    cnt_d             = cnt_q;
    cin_d             = cin_q;
    carry_d           = carry_q;
    cout_d            = cout_q;
    shifter_operation = PASS_THROUGH;
    shifter_in        = work_q;
    shifter_cin       = cin_q;
    busy              = 1'b0;
    done              = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = operation;
          work_d  = in;
          cin_d   = cin;
          carry_d = 1'b0;
          cnt_d   = effCount;
          if (effCount == '0) begin
            out_d   = in;
            cout_d  = 1'b0;
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        busy              = 1'b1;
        shifter_operation = op_q;
        work_d            = shifter_out;
        carry_d           = shifter_cout;
        cnt_d             = cnt_q - COUNT_WIDTH'(1);
        // Last pass: publish the fresh shifter result directly.
        if (cnt_q == COUNT_WIDTH'(1)) begin
          out_d   = shifter_out;
          cout_d  = shifter_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out  = out_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer; a behavioural single-pass shifter closes
// the loop so the sequencer's pass count, latency and latching can be checked.

module tb_shift_sequencer;
  import shift_sequencer_pkg::*;

  logic               clk;
  logic               rst;
  logic               start;
  SHIFTER_OPERATION   operation;
  MICRO1_MACHINE_WORD in;
  logic [3:0]         count;
  logic               cin;
  SHIFTER_OPERATION   shifterOperation;
  MICRO1_MACHINE_WORD shifterIn;
  logic               shifterCin;
  MICRO1_MACHINE_WORD shifterOut;
  logic               shifterCout;
  MICRO1_MACHINE_WORD out;
  logic               cout;
  logic               busy;
  logic               done;

  int testsRun;
  int testsFailed;

  MICRO1_MACHINE_WORD trace [0:15];
  logic               traceC [0:15];
  int                 nTrace;
  MICRO1_MACHINE_WORD outAtStart;

  shift_sequencer #(.COUNT_WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .operation(operation),
    .in(in),
    .count(count),
    .cin(cin),
    .shifter_operation(shifterOperation),
    .shifter_in(shifterIn),
    .shifter_cin(shifterCin),
    .shifter_out(shifterOut),
    .shifter_cout(shifterCout),
    .out(out),
    .cout(cout),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference single-pass shifter: fill bit from cin, carry is the bit shifted out.
  always_comb begin
    shifterOut  = shifterIn;
    shifterCout = 1'b0;
    case (shifterOperation)
      LEFT_LOGICALLY, LEFT_ARITHMETICALLY: begin
        shifterOut  = {shifterIn[14:0], shifterCin};
        shifterCout = shifterIn[15];
      end
      RIGHT_LOGICALLY: begin
        shifterOut  = {shifterCin, shifterIn[15:1]};
        shifterCout = shifterIn[0];
      end
      RIGHT_ARITHMETICALLY: begin
        shifterOut  = {shifterIn[15], shifterIn[15:1]};
        shifterCout = shifterIn[0];
      end
      EXTENSION: shifterOut = {{8{shifterIn[7]}}, shifterIn[7:0]};
      SWAP:      shifterOut = {shifterIn[7:0], shifterIn[15:8]};
      default: ;
    endcase
  end

  task automatic applyStimulus(input SHIFTER_OPERATION op, input MICRO1_MACHINE_WORD word,
                               input logic [3:0] cnt, input logic c);
    @(negedge clk);
    operation = op;
    in        = word;
    count     = cnt;
    cin       = c;
    start     = 1'b1;
  endtask

  // Steps whole cycles after a start, scrambling inputs once the start is taken
  // and optionally re-pulsing start at cycle restartAt.
  task automatic runCycles(input int limit, input int restartAt,
                           output int firstDone, output int doneCount);
    firstDone = -1;
    doneCount = 0;
    nTrace    = 0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (c == 1) outAtStart = out;
      if (busy && nTrace < 16) begin
        trace[nTrace]  = shifterOut;
        traceC[nTrace] = shifterCout;
        nTrace++;
      end
      if (done) begin
        doneCount++;
        if (firstDone < 0) firstDone = c;
      end
      if (c == 1) begin
        start     = 1'b0;
        operation = SWAP;
        in        = 16'h5A5A;
        count     = 4'hF;
        cin       = 1'b1;
      end
      if (restartAt > 0 && c == restartAt) begin
        start     = 1'b1;
        operation = RIGHT_LOGICALLY;
        in        = 16'hFFFF;
      end
      if (restartAt > 0 && c == restartAt + 1) start = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    testsRun++;
    if (out !== 16'h0000 || cout !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_out: got out=%h cout=%b, want 0000/0", out, cout);
    end
    testsRun++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_flags: got busy=%b done=%b, want 0/0", busy, done);
    end
    testsRun++;
    if (shifterOperation !== PASS_THROUGH || shifterIn !== 16'h0000) begin
      testsFailed++;
      $display("[TB] FAIL reset_shifter: got op=%0d in=%h, want 0/0000", shifterOperation, shifterIn);
    end
    rst = 1'b0;
  endtask

  task automatic test_left_logical();
    int first, nd;
    applyStimulus(LEFT_LOGICALLY, 16'h8001, 4'd3, 1'b0);
    runCycles(10, 0, first, nd);
    testsRun++;
    if (first != 4 || nd != 1) begin
      testsFailed++;
      $display("[TB] FAIL left_latency: got done at %0d (count %0d), want 4 (1)", first, nd);
    end
    testsRun++;
    if (outAtStart !== 16'h0000) begin
      testsFailed++;
      $display("[TB] FAIL left_out_held: got %h before done, want 0000", outAtStart);
    end
    testsRun++;
    if (nTrace != 3 || trace[0] !== 16'h0002 || trace[1] !== 16'h0004 || trace[2] !== 16'h0008
        || traceC[0] !== 1'b1 || traceC[1] !== 1'b0 || traceC[2] !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL left_passes: got n=%0d %h/%b %h/%b %h/%b, want 3 0002/1 0004/0 0008/0",
               nTrace, trace[0], traceC[0], trace[1], traceC[1], trace[2], traceC[2]);
    end
    testsRun++;
    if (out !== 16'h0008 || cout !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL left_result: got %h/%b, want 0008/0", out, cout);
    end
    testsRun++;
    if (shifterOperation !== PASS_THROUGH || shifterIn !== 16'h0008) begin
      testsFailed++;
      $display("[TB] FAIL left_idle_drive: got op=%0d in=%h, want 0/0008", shifterOperation, shifterIn);
    end
  endtask

  task automatic test_right_arith();
    int first, nd;
    applyStimulus(RIGHT_ARITHMETICALLY, 16'h8004, 4'd3, 1'b0);
    runCycles(8, 0, first, nd);
    testsRun++;
    if (first != 4 || nd != 1) begin
      testsFailed++;
      $display("[TB] FAIL rarith_latency: got done at %0d (count %0d), want 4 (1)", first, nd);
    end
    testsRun++;
    if (nTrace != 3 || trace[0] !== 16'hC002 || trace[1] !== 16'hE001 || trace[2] !== 16'hF000) begin
      testsFailed++;
      $display("[TB] FAIL rarith_passes: got n=%0d %h %h %h, want 3 C002 E001 F000",
               nTrace, trace[0], trace[1], trace[2]);
    end
    testsRun++;
    if (out !== 16'hF000 || cout !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL rarith_result: got %h/%b, want F000/1", out, cout);
    end
  endtask

  task automatic test_zero_count();
    int first, nd;
    applyStimulus(LEFT_LOGICALLY, 16'hABCD, 4'd0, 1'b1);
    runCycles(5, 0, first, nd);
    testsRun++;
    if (first != 1 || nd != 1 || nTrace != 0) begin
      testsFailed++;
      $display("[TB] FAIL zero_latency: got done at %0d (count %0d, passes %0d), want 1 (1, 0)",
               first, nd, nTrace);
    end
    testsRun++;
    if (out !== 16'hABCD || cout !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL zero_result: got %h/%b, want ABCD/0", out, cout);
    end
  endtask

  task automatic test_swap();
    int first, nd;
    applyStimulus(SWAP, 16'h1234, 4'd5, 1'b0);
    runCycles(6, 0, first, nd);
    testsRun++;
    if (first != 2 || nd != 1 || nTrace != 1) begin
      testsFailed++;
      $display("[TB] FAIL swap_latency: got done at %0d (count %0d, passes %0d), want 2 (1, 1)",
               first, nd, nTrace);
    end
    testsRun++;
    if (outAtStart !== 16'hABCD) begin
      testsFailed++;
      $display("[TB] FAIL swap_out_held: got %h before done, want ABCD", outAtStart);
    end
    testsRun++;
    if (out !== 16'h3412 || cout !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL swap_result: got %h/%b, want 3412/0", out, cout);
    end
  endtask

  task automatic test_extension_zero_count();
    int first, nd;
    applyStimulus(EXTENSION, 16'h0080, 4'd0, 1'b0);
    runCycles(6, 0, first, nd);
    testsRun++;
    if (first != 2 || nd != 1) begin
      testsFailed++;
      $display("[TB] FAIL ext_latency: got done at %0d (count %0d), want 2 (1)", first, nd);
    end
    testsRun++;
    if (out !== 16'hFF80 || cout !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL ext_result: got %h/%b, want FF80/0", out, cout);
    end
  endtask

  task automatic test_right_logical_fill();
    int first, nd;
    applyStimulus(RIGHT_LOGICALLY, 16'h8001, 4'd1, 1'b1);
    runCycles(5, 0, first, nd);
    testsRun++;
    if (first != 2 || out !== 16'hC000 || cout !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL rlog_fill: got done at %0d out=%h/%b, want 2 C000/1", first, out, cout);
    end
  endtask

  task automatic test_back_to_back();
    int first, nd;
    applyStimulus(LEFT_LOGICALLY, 16'h0003, 4'd15, 1'b0);
    runCycles(22, 3, first, nd);
    testsRun++;
    if (first != 16 || nd != 1) begin
      testsFailed++;
      $display("[TB] FAIL b2b_latency: got done at %0d (count %0d), want 16 (1)", first, nd);
    end
    testsRun++;
    if (out !== 16'h8000 || cout !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL b2b_result: got %h/%b, want 8000/1", out, cout);
    end
  endtask

  task automatic test_reset_abort();
    int first, nd;
    applyStimulus(LEFT_LOGICALLY, 16'h0003, 4'd15, 1'b0);
    runCycles(5, 0, first, nd);
    #2 rst = 1'b1;
    #1;
    testsRun++;
    if (out !== 16'h0000 || cout !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || shifterIn !== 16'h0000) begin
      testsFailed++;
      $display("[TB] FAIL abort_clear: got out=%h cout=%b busy=%b done=%b work=%h, want 0000/0/0/0/0000",
               out, cout, busy, done, shifterIn);
    end
    @(negedge clk);
    rst = 1'b0;
    runCycles(20, 0, first, nd);
    testsRun++;
    if (nd != 0) begin
      testsFailed++;
      $display("[TB] FAIL abort_no_done: got %0d done pulses, want 0", nd);
    end
    applyStimulus(SWAP, 16'hBEEF, 4'd3, 1'b0);
    runCycles(6, 0, first, nd);
    testsRun++;
    if (first != 2 || nd != 1 || out !== 16'hEFBE || cout !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL abort_restart: got done at %0d (count %0d) out=%h/%b, want 2 (1) EFBE/0",
               first, nd, out, cout);
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst         = 1'b1;
    start       = 1'b0;
    operation   = PASS_THROUGH;
    in          = 16'h0000;
    count       = 4'd0;
    cin         = 1'b0;
    test_reset();
    test_left_logical();
    test_right_arith();
    test_zero_count();
    test_swap();
    test_extension_zero_count();
    test_right_logical_fill();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have parameter COUNT_WIDTH, default 4, which is the width of the shift-count port (maximum count 2^COUNT_WIDTH-1).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a new shift; sampled only in IDLE.
REQ-005 The block SHALL have port operation, input, SHIFTER_OPERATION: the requested shift kind.
REQ-006 The block SHALL have port in, input, MICRO1_MACHINE_WORD (16 bits): the operand.
REQ-007 The block SHALL have port count, input, COUNT_WIDTH bits: the number of one-bit passes.
REQ-008 The block SHALL have port cin, input, 1 bit: the carry/fill bit applied on every pass.
REQ-009 The block SHALL have port shifter_operation, output, SHIFTER_OPERATION: drives the single-pass shifter.
REQ-010 The block SHALL have port shifter_in, output, 16 bits: the working word driven to the shifter.
REQ-011 The block SHALL have port shifter_cin, output, 1 bit: the latched cin driven to the shifter.
REQ-012 The block SHALL have port shifter_out, input, 16 bits: the shifter result for the current pass.
REQ-013 The block SHALL have port shifter_cout, input, 1 bit: the shifter carry for the current pass.
REQ-014 The block SHALL have port out, output, 16 bits: the registered final result, held until the next start.
REQ-015 The block SHALL have port cout, output, 1 bit: the registered final carry, held until the next start.
REQ-016 The block SHALL have port busy, output, 1 bit: high in SHIFT state.
REQ-017 The block SHALL have port done, output, 1 bit: a one-cycle pulse when out/cout become valid.

Function
REQ-018 The FSM SHALL have states IDLE, SHIFT, DONE.
REQ-019 In IDLE with start=1, the block SHALL latch operation, in, cin, and count into the working registers (work=in).
REQ-020 From IDLE, the block SHALL go to SHIFT if the effective pass count is nonzero, else to DONE.
REQ-021 Effective pass count: LEFT/RIGHT LOGICALLY/ARITHMETICALLY SHALL use count; any other operation (EXTENSION, SWAP, default) SHALL be exactly 1 pass regardless of count, including count=0.
REQ-022 With an effective pass count of 0, the block SHALL set out=in and cout=0.
REQ-023 In SHIFT, each cycle the block SHALL drive shifter_in=work, shifter_operation=latched op, and shifter_cin=latched cin; it SHALL load work<=shifter_out and carry<=shifter_cout, and decrement the remaining count.
REQ-024 When the remaining count reaches 0 after a pass, the block SHALL copy work/carry to out/cout and enter DONE.
REQ-025 In DONE, the block SHALL assert done for exactly that cycle and return to IDLE next cycle.
REQ-026 Latency: start sampled at edge T, the block SHALL assert done in cycle T+n+1 for n effective passes (n=0 gives T+1).
REQ-027 The block SHALL ignore start in SHIFT and DONE, and SHALL NOT disturb in-flight work.
REQ-028 The block SHALL keep out/cout stable from done until the cycle after the next accepted start completes.
REQ-029 In IDLE and DONE, the block SHALL drive shifter_operation to the default (pass-through) code and shifter_in=work.
REQ-030 Input changes on operation/in/count/cin after acceptance SHALL have no effect.

Reset
REQ-031 On rst=1, at any time including mid-SHIFT, the block SHALL immediately set state=IDLE, out=0, cout=0, busy=0, done=0, work=0, and remaining count=0.
REQ-032 An aborted operation SHALL produce no done pulse; the first start after rst deasserts SHALL be accepted normally.

Verification
REQ-033 LEFT_LOGICALLY, in=0x8001, count=3, cin=0 -> passes 0x0002/c1, 0x0004/c0, 0x0008/c0; done at T+4; out=0x0008, cout=0.
REQ-034 RIGHT_ARITHMETICALLY, in=0x8004, count=3 -> passes 0xC002, 0xE001, 0xF000; done at T+4; out=0xF000, cout=1.
REQ-035 SWAP, in=0x1234, count=5 -> single pass; done at T+2; out=0x3412, cout=0.
REQ-036 LEFT_LOGICALLY, in=0xABCD, count=0 -> no shifter pass; done at T+1; out=0xABCD, cout=0.
REQ-037 Start with count=15, then pulse start again at T+3 -> second start is ignored, exactly one done at T+16.
REQ-038 Start with count=15, assert rst at T+5 -> out/cout/busy/done go to 0 immediately with no done pulse; a new start after release completes correctly.
